wavegen_scheduler: RTL and testbench
====================================

// Module: wavegen_scheduler
// PURPOSE
//  Time-multiplexes one shared oscillator datapath across NUM_VOICES wavegen_t voice slots.
//  - Once per sample period it issues every voice's config and index to the oscillator in turn.
//  - It sums the returned samples into one mixed sample, then hands that sample downstream
//    on a valid/ready interface.
//  - Sits between the protocol register file (voice_cfg) and the oscillator/output stage.
// PARAMETERS
//  NUM_VOICES   16                            voice slots scheduled per sample period
//  OSC_LATENCY  2                             cycles from osc_enable to matching osc_out
//  OSC_WIDTH    `SAMPLE_WIDTH+`FIXED_POINT    signed width of oscillator output
//  OUT_WIDTH    `SAMPLE_WIDTH                 signed width of mixed sample
//  MIX_SHIFT    `FIXED_POINT                  arithmetic right shift applied to sum before narrowing
// PORTS
//  clk            in   1                      system clock
//  rst            in   1                      reset, asynchronous, active-high
//  sample_tick    in   1                      one-cycle strobe, start of sample period
//  voice_cfg      in   wavegen_t[NUM_VOICES]  per-voice config from protocol registers
//  osc_enable     out  1                      oscillator computes issued voice this cycle
//  osc_voice_idx  out  $clog2(NUM_VOICES)     voice index, selects oscillator state bank
//  osc_wavegen    out  wavegen_t              registered copy of voice_cfg[osc_voice_idx]
//  osc_out        in   OSC_WIDTH signed       oscillator sample, OSC_LATENCY after issue
//  mix_out        out  OUT_WIDTH signed       mixed sample
//  mix_valid      out  1                      mix_out valid; held until mix_ready
//  mix_ready      in   1                      downstream accepts mix_out
//  busy           out  1                      state != IDLE
//  overrun        out  1                      one-cycle pulse: sample_tick dropped
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, pipeline flags=0.
//    All outputs 0: osc_enable, osc_voice_idx, osc_wavegen='0, mix_out, mix_valid, busy, overrun.
//  - FSM: IDLE -> ISSUE -> DRAIN -> OUTPUT -> IDLE.
//  - IDLE: sample_tick=1 -> clear acc, idx=0, go ISSUE.
//  - ISSUE, one voice per cycle:
//    - osc_voice_idx=idx; osc_wavegen=voice_cfg[idx].
//    - osc_enable = voice_cfg[idx].cmds[`WAVEGEN_ENABLE_BIT].
//    - Cycle after tick presents idx 0. idx=NUM_VOICES-1 -> DRAIN.
//  - Valid pipeline: an OSC_LATENCY-deep shift of osc_enable.
//    - acc += sign-extended osc_out only when the delayed flag is 1.
//    - A disabled voice contributes 0.
//  - DRAIN: OSC_LATENCY cycles; osc_enable=0; accumulation continues, then OUTPUT.
//  - Accumulator width: OSC_WIDTH+$clog2(NUM_VOICES); never overflows.
//  - OUTPUT:
//    - mix_out = narrow(acc >>> MIX_SHIFT); mix_valid=1.
//    - Latency: mix_valid rises NUM_VOICES+OSC_LATENCY+1 cycles after the tick edge.
//    - mix_valid && mix_ready -> mix_valid=0, IDLE in the same edge.
//    - mix_out stays stable while mix_valid=1 && !mix_ready.
//  - sample_tick while state != IDLE (including the OUTPUT/accept cycle):
//    overrun=1 for one cycle, tick dropped, current period unaffected.
//  - voice_cfg changes mid-period are sampled at each voice's own issue cycle; no snapshot.
//  - ENVELOPE_RESET_BIT and the other cmds bits pass through osc_wavegen unmodified.
//  - rst mid-operation: immediate return to reset values; the partial sum is discarded.
// CONFIGURATION
//  MIXER_SATURATION_EN
//  - Defined: narrow() clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  - Undefined: narrow() keeps the low OUT_WIDTH bits (two's-complement wrap).
// STRUCTURE
//  - sched_pkg: sched_state_t enum {IDLE,ISSUE,DRAIN,OUTPUT}, VOICE_IDX_W function/constant.
//  - wavegen_t and the cmds bit macros stay in protocol_pkg/constants.svh.
//  - Sub-module voice_mix_acc: clear/add/shift/narrow.
//    - Holds the accumulator and the saturation (MIXER_SATURATION_EN) logic.
//  - FSM, index counter and valid pipeline stay in wavegen_scheduler.
// TESTING (NUM_VOICES=4, OSC_LATENCY=2, OSC_WIDTH=OUT_WIDTH=24, MIX_SHIFT=0, behavioural osc model)
//  1. All 4 voices enabled, osc_out=1000 each.
//     -> mix_out=4000; mix_valid high exactly 7 cycles after tick; busy high in between.
//  2. Voice 2 ENABLE bit clear, others 1000.
//     -> osc_enable=0 on idx-2 cycle; mix_out=3000.
//  3. Four voices at 24'h400000 each:
//     -> with MIXER_SATURATION_EN mix_out=24'h7FFFFF, else 24'h000000.
//     Four voices at -24'h400000 each:
//     -> with MIXER_SATURATION_EN mix_out=24'h800000, else 0.
//  4. mix_ready low 5 cycles, sample_tick pulsed during the hold.
//     -> mix_valid/mix_out stable; overrun one-cycle pulse; no new period.
//     -> IDLE after handshake; the next tick works normally.
//  5. rst asserted during ISSUE idx 1.
//     -> all outputs 0 immediately; the following tick yields 4000, not a partial sum.
//  6. voice_cfg[3].cmds ENVELOPE_RESET_BIT=1, freq=`REAL_TO_FIXED_POINT(440).
//     -> osc_wavegen equals voice_cfg[3] on the idx-3 issue cycle.

Source files
------------

// File: rtl/protocol_pkg.sv
// Per-voice configuration record written by the protocol register file.
`include "constants.svh"

package protocol_pkg;

  localparam int ENABLE_BIT    = `WAVEGEN_ENABLE_BIT;
  localparam int ENV_RESET_BIT = `ENVELOPE_RESET_BIT;
  localparam int FIXED_POINT   = `FIXED_POINT;

  typedef struct packed {
    logic [7:0]  cmds;
    logic [31:0] freq;
    logic [15:0] amplitude;
  } wavegen_t;

endpackage

// File: rtl/sched_pkg.sv
// Scheduler state encoding and voice-index width helper.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT
  } sched_state_t;

  function automatic int voice_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/constants.svh
// Shared widths, command-bit positions and fixed-point helpers for the wavegen protocol.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define SAMPLE_WIDTH       24
`define FIXED_POINT        8
`define WAVEGEN_ENABLE_BIT 0
`define ENVELOPE_RESET_BIT 1
`define REAL_TO_FIXED_POINT(x) (int'((x) * (2.0 ** `FIXED_POINT)))

`endif

// File: rtl/voice_mix_acc.sv
// Mix accumulator: clear, add sign-extended voice samples, shift and narrow to OUT_WIDTH.
// MIXER_SATURATION_EN defined: narrowing clamps; undefined: narrowing wraps.
module voice_mix_acc #(
  parameter int OSC_WIDTH = 32,
  parameter int ACC_WIDTH = 36,
  parameter int OUT_WIDTH = 24,
  parameter int MIX_SHIFT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        add_en,
  input  logic signed [OSC_WIDTH-1:0] add_val,
  output logic signed [OUT_WIDTH-1:0] mix
);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + {{(ACC_WIDTH-OSC_WIDTH){add_val[OSC_WIDTH-1]}}, add_val};
    end
  end

  assign shifted = acc >>> MIX_SHIFT;

`ifdef MIXER_SATURATION_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    mix = OUT_WIDTH'(shifted);
    if (shifted > SAT_MAX) begin
      mix = OUT_WIDTH'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      mix = OUT_WIDTH'(SAT_MIN);
    end
  end
`else
  assign mix = OUT_WIDTH'(shifted);
`endif

endmodule

// File: rtl/wavegen_scheduler.sv
// Time-multiplexes one oscillator over NUM_VOICES voices per sample period and emits the mix
// on valid/ready; mix valid NUM_VOICES+OSC_LATENCY+1 cycles after tick (MIXER_SATURATION_EN selects clamp).
`include "constants.svh"

module wavegen_scheduler
  import protocol_pkg::*;
  import sched_pkg::*;
#(
  parameter int NUM_VOICES  = 16,
  parameter int OSC_LATENCY = 2,
  parameter int OSC_WIDTH   = `SAMPLE_WIDTH + `FIXED_POINT,
  parameter int OUT_WIDTH   = `SAMPLE_WIDTH,
  parameter int MIX_SHIFT   = `FIXED_POINT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sample_tick,
  input  wavegen_t                                voice_cfg [NUM_VOICES],
  output logic                                    osc_enable,
  output logic [voice_idx_w(NUM_VOICES)-1:0]      osc_voice_idx,
  output wavegen_t                                osc_wavegen,
  input  logic signed [OSC_WIDTH-1:0]             osc_out,
  output logic signed [OUT_WIDTH-1:0]             mix_out,
  output logic                                    mix_valid,
  input  logic                                    mix_ready,
  output logic                                    busy,
  output logic                                    overrun
);

  localparam int IDX_W   = voice_idx_w(NUM_VOICES);
  localparam int ACC_W   = OSC_WIDTH + $clog2(NUM_VOICES);
  localparam int DRAIN_W = $clog2(OSC_LATENCY + 1);

  sched_state_t              state;
  logic [OSC_LATENCY-1:0]    vld_pipe;
  logic [DRAIN_W-1:0]        drain_cnt;
  logic [IDX_W-1:0]          next_idx;
  logic signed [OUT_WIDTH-1:0] mix_narrow;
  logic                      acc_clear;

  assign next_idx  = osc_voice_idx + 1'b1;
  assign acc_clear = (state == IDLE) && sample_tick;
  assign busy      = (state != IDLE);

  // Tags each oscillator result slot with whether its voice was actually enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= osc_enable;
      for (int i = 1; i < OSC_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  voice_mix_acc #(
    .OSC_WIDTH (OSC_WIDTH),
    .ACC_WIDTH (ACC_W),
    .OUT_WIDTH (OUT_WIDTH),
    .MIX_SHIFT (MIX_SHIFT)
  ) u_mix_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .add_en  (vld_pipe[OSC_LATENCY-1]),
    .add_val (osc_out),
    .mix     (mix_narrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      osc_enable    <= 1'b0;
      osc_voice_idx <= '0;
      osc_wavegen   <= '0;
      mix_out       <= '0;
      mix_valid     <= 1'b0;
      overrun       <= 1'b0;
      drain_cnt     <= '0;
    end else begin
      overrun <= sample_tick && (state != IDLE);
      case (state)
        IDLE: begin
          osc_enable <= 1'b0;
          if (sample_tick) begin
            state         <= ISSUE;
            osc_voice_idx <= '0;
            osc_wavegen   <= voice_cfg[0];
            osc_enable    <= voice_cfg[0].cmds[ENABLE_BIT];
          end
        end
        ISSUE: begin
          if (osc_voice_idx == IDX_W'(NUM_VOICES - 1)) begin
            state      <= DRAIN;
            osc_enable <= 1'b0;
            drain_cnt  <= '0;
          end else begin
            osc_voice_idx <= next_idx;
            osc_wavegen   <= voice_cfg[next_idx];
            osc_enable    <= voice_cfg[next_idx].cmds[ENABLE_BIT];
          end
        end
        // The extra count lets the last accumulate land before the mix is registered.
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(OSC_LATENCY)) begin
            state     <= OUTPUT;
            mix_out   <= mix_narrow;
            mix_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (mix_ready) begin
            mix_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavegen_scheduler.sv
// Directed bench for wavegen_scheduler with a 2-cycle behavioural oscillator model.
module tb_wavegen_scheduler;
  import protocol_pkg::*;

  localparam int NV  = 4;
  localparam int LAT = 2;
  localparam int W   = 24;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_tick = 1'b0;
  logic                mix_ready = 1'b0;
  wavegen_t            voice_cfg [NV];
  logic                osc_enable;
  logic [1:0]          osc_voice_idx;
  wavegen_t            osc_wavegen;
  logic signed [W-1:0] osc_out;
  logic signed [W-1:0] mix_out;
  logic                mix_valid;
  logic                busy;
  logic                overrun;

  always #5 clk = ~clk;

  wavegen_scheduler #(
    .NUM_VOICES  (NV),
    .OSC_LATENCY (LAT),
    .OSC_WIDTH   (W),
    .OUT_WIDTH   (W),
    .MIX_SHIFT   (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .voice_cfg     (voice_cfg),
    .osc_enable    (osc_enable),
    .osc_voice_idx (osc_voice_idx),
    .osc_wavegen   (osc_wavegen),
    .osc_out       (osc_out),
    .mix_out       (mix_out),
    .mix_valid     (mix_valid),
    .mix_ready     (mix_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  // Oscillator model: disabled issues return junk that must never reach the mix.
  logic signed [W-1:0] osc_val [NV];
  logic signed [W-1:0] osc_p1, osc_p2;
  always @(posedge clk) begin
    osc_p1 <= osc_enable ? osc_val[osc_voice_idx] : 24'sd777;
    osc_p2 <= osc_p1;
  end
  assign osc_out = osc_p2;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic     en_cap [NV];
  wavegen_t wg_cap [NV];

  task automatic finish_handshake(input string tag);
    mix_ready = 1'b1;
    @(negedge clk);
    mix_ready = 1'b0;
    check({tag, "_vld_drop"}, mix_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic run_period(input string tag, input logic signed [W-1:0] exp_mix, input bit ack);
    int cyc;
    bit busy_ok;
    bit idx_ok;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    idx_ok = 1'b1;
    while (!mix_valid && cyc < 30) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc < NV) begin
        en_cap[cyc] = osc_enable;
        wg_cap[cyc] = osc_wavegen;
        if (osc_voice_idx != cyc[1:0]) idx_ok = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 7);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_idx_seq"}, idx_ok, 1'b1);
    check({tag, "_mix"}, mix_out, exp_mix);
    if (ack) finish_handshake(tag);
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      voice_cfg[i] = '0;
      voice_cfg[i].cmds[ENABLE_BIT] = 1'b1;
      voice_cfg[i].freq = 32'(100 * (i + 1));
      voice_cfg[i].amplitude = 16'h1000;
      osc_val[i] = 24'sd1000;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_osc_enable", osc_enable, 1'b0);
    check("rst_osc_idx", osc_voice_idx, 2'd0);
    check("rst_osc_wavegen", osc_wavegen, '0);
    check("rst_mix_out", mix_out, '0);
    check("rst_mix_valid", mix_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    // 1: all voices enabled
    run_period("t1", 24'sd4000, 1'b1);
    for (int i = 0; i < NV; i++) check("t1_enable", en_cap[i], 1'b1);

    // 2: voice 2 disabled
    voice_cfg[2].cmds[ENABLE_BIT] = 1'b0;
    run_period("t2", 24'sd3000, 1'b1);
    check("t2_en_idx2", en_cap[2], 1'b0);
    check("t2_en_idx1", en_cap[1], 1'b1);
    voice_cfg[2].cmds[ENABLE_BIT] = 1'b1;

    // Mixed-sign sum: 1000 - 3000 + 500 + 2
    osc_val[1] = -24'sd3000;
    osc_val[2] = 24'sd500;
    osc_val[3] = 24'sd2;
    run_period("mixed", -24'sd1498, 1'b1);

    // 3: overflow in both directions
    for (int i = 0; i < NV; i++) osc_val[i] = 24'sh400000;
`ifdef MIXER_SATURATION_EN
    run_period("t3_pos", 24'sh7FFFFF, 1'b1);
`else
    run_period("t3_pos", 24'sh000000, 1'b1);
`endif
    for (int i = 0; i < NV; i++) osc_val[i] = -24'sh400000;
`ifdef MIXER_SATURATION_EN
    run_period("t3_neg", 24'sh800000, 1'b1);
`else
    run_period("t3_neg", 24'sh000000, 1'b1);
`endif

    // 4: backpressure hold with a dropped tick, then tick on the accept cycle
    for (int i = 0; i < NV; i++) osc_val[i] = 24'sd1000;
    run_period("t4", 24'sd4000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sample_tick = (i == 1);
      @(negedge clk);
      sample_tick = 1'b0;
      check("t4_hold_vld", mix_valid, 1'b1);
      check("t4_hold_mix", mix_out, 24'sd4000);
      check("t4_overrun", overrun, (i == 1));
      check("t4_no_issue", osc_enable, 1'b0);
    end
    mix_ready = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    mix_ready = 1'b0;
    sample_tick = 1'b0;
    check("t4_accept_vld", mix_valid, 1'b0);
    check("t4_accept_idle", busy, 1'b0);
    check("t4_accept_overrun", overrun, 1'b1);
    @(negedge clk);
    check("t4_still_idle", busy, 1'b0);
    run_period("t4_next", 24'sd4000, 1'b1);

    // 5: reset mid-issue
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    check("t5_idx_before", osc_voice_idx, 2'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_idx", osc_voice_idx, 2'd0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_wavegen", osc_wavegen, '0);
    check("t5_rst_enable", osc_enable, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_period("t5", 24'sd4000, 1'b1);

    // 6: envelope-reset and frequency pass through untouched
    voice_cfg[3].cmds = '0;
    voice_cfg[3].cmds[ENABLE_BIT] = 1'b1;
    voice_cfg[3].cmds[ENV_RESET_BIT] = 1'b1;
    voice_cfg[3].freq = 32'(440 << FIXED_POINT);
    voice_cfg[3].amplitude = 16'hBEEF;
    run_period("t6", 24'sd4000, 1'b1);
    check("t6_wavegen3", wg_cap[3], {8'h03, 32'd112640, 16'hBEEF});
    check("t6_wavegen0", wg_cap[0], {8'h01, 32'd100, 16'h1000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
